register_2b: RTL and testbench

Two-bit storage register with clock enable and asynchronous clear. It is the smallest register slice of the 8-bit CPU datapath. It holds two independent data bits that load together on a clock edge when enabled. Wider registers in the CPU are composed from this block or follow the same contract.

---
 rtl/register_2b_pkg.sv | 9 +
 rtl/register_2b_if.sv | 27 ++
 rtl/register_2b_dff_ce_ar.sv | 30 +++
 rtl/register_2b.sv | 36 +++
 tb/tb_register_2b.sv | 108 ++++++++++
 5 files changed

// File: rtl/register_2b_pkg.sv
// Shared constants for the two-bit register slice of the CPU datapath.
package register_2b_pkg;

    localparam int unsigned REG_WIDTH = 2;

    // Value both bits take while clear is asserted.
    localparam logic [REG_WIDTH-1:0] CLEAR_VALUE = '0;

endpackage

// File: rtl/register_2b_if.sv
// Data/enable bundle around a register_2b slice; clock and clear travel separately.
// Handshake: none; the producer drives d0/d1/clock_enable, the register returns q0/q1.
interface register_2b_if;

    logic d0;
    logic d1;
    logic clock_enable;
    logic q0;
    logic q1;

    modport master (
        output d0,
        output d1,
        output clock_enable,
        input  q0,
        input  q1
    );

    modport slave (
        input  d0,
        input  d1,
        input  clock_enable,
        output q0,
        output q1
    );

endinterface

// File: rtl/register_2b_dff_ce_ar.sv
// One-bit D flip-flop with load enable and asynchronous active-high clear.
// Enable is a hold mux in front of the flop, so the clock is never gated.
module dff_ce_ar #(
    parameter logic RESET_VALUE = 1'b0
) (
    input  logic clock,
    input  logic clear,
    input  logic clock_enable,
    input  logic d,
    output logic q
);

    logic d_next;

    always_comb begin
        d_next = q;
        if (clock_enable) begin
            d_next = d;
        end
    end

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            q <= RESET_VALUE;
        end else begin
            q <= d_next;
        end
    end

endmodule

// File: rtl/register_2b.sv
// Two-bit register slice: both bits share clock, enable and clear, and load together.
module register_2b
    import register_2b_pkg::*;
(
    input  logic d0,
    input  logic d1,
    input  logic clock,
    input  logic clock_enable,
    input  logic clear,
    output logic q0,
    output logic q1
);

    localparam logic [REG_WIDTH-1:0] RESET_BITS = CLEAR_VALUE;

    dff_ce_ar #(
        .RESET_VALUE (RESET_BITS[0])
    ) u_bit0 (
        .clock        (clock),
        .clear        (clear),
        .clock_enable (clock_enable),
        .d            (d0),
        .q            (q0)
    );

    dff_ce_ar #(
        .RESET_VALUE (RESET_BITS[1])
    ) u_bit1 (
        .clock        (clock),
        .clear        (clear),
        .clock_enable (clock_enable),
        .d            (d1),
        .q            (q1)
    );

endmodule

// File: tb/tb_register_2b.sv
// Directed, table-driven bench for register_2b with hand-written clear/timing sequences.
module tb_register_2b;

    logic clock;
    logic clear;
    int   tests_run;
    int   tests_failed;

    register_2b_if bus ();

    register_2b dut (
        .d0           (bus.d0),
        .d1           (bus.d1),
        .clock        (clock),
        .clock_enable (bus.clock_enable),
        .clear        (clear),
        .q0           (bus.q0),
        .q1           (bus.q1)
    );

    // 50-unit period, first rising edge at t=25.
    initial begin
        clock = 1'b0;
        forever #25 clock = ~clock;
    end

    typedef struct {
        string      name;
        logic [1:0] d;
        logic       ce;
        logic       clr;
        logic [1:0] exp_pre;
        logic [1:0] exp_post;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [1:0] exp);
        logic [1:0] act;
        act = {bus.q1, bus.q0};
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: q1:q0 got %b expected %b at t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [1:0] d, input logic ce, input logic clr);
        bus.d1           = d[1];
        bus.d0           = d[0];
        bus.clock_enable = ce;
        clear            = clr;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{"load_zeros",    2'b00, 1'b1, 1'b0, 2'b00, 2'b00};
        vecs[1] = '{"load_ones",     2'b11, 1'b1, 1'b0, 2'b00, 2'b11};
        vecs[2] = '{"async_clear",   2'b11, 1'b1, 1'b1, 2'b00, 2'b00};
        vecs[3] = '{"clear_release", 2'b01, 1'b1, 1'b0, 2'b00, 2'b01};
        vecs[4] = '{"load_10",       2'b10, 1'b1, 1'b0, 2'b01, 2'b10};
        vecs[5] = '{"hold_a",        2'b01, 1'b0, 1'b0, 2'b10, 2'b10};
        vecs[6] = '{"hold_b",        2'b11, 1'b0, 1'b0, 2'b10, 2'b10};

        // Power-up with enable off, then a clear pulse before the first edge.
        drive(2'b00, 1'b0, 1'b0);
        #10 clear = 1'b1;
        #1 check("init_clear_immediate", 2'b00);
        #9 clear = 1'b0;
        @(posedge clock); #1 check("enable_off_edge1", 2'b00);
        @(posedge clock); #1 check("enable_off_edge2", 2'b00);

        // Each record: apply at a falling edge, check before and after two rising edges.
        for (int i = 0; i < 7; i++) begin
            @(negedge clock);
            drive(vecs[i].d, vecs[i].ce, vecs[i].clr);
            #1 check({vecs[i].name, "_pre"}, vecs[i].exp_pre);
            for (int e = 0; e < 2; e++) begin
                @(posedge clock);
                #1 check({vecs[i].name, "_post"}, vecs[i].exp_post);
            end
        end

        // Data changes between edges and falling edges must not disturb q.
        @(negedge clock);
        drive(2'b01, 1'b1, 1'b0);
        @(posedge clock); #1 check("seq_load_01", 2'b01);
        #5 bus.d1 = 1'b1; bus.d0 = 1'b0;
        #1 check("seq_mid_cycle_data", 2'b01);
        @(negedge clock); #1 check("seq_falling_edge", 2'b01);
        @(posedge clock); #1 check("seq_load_10", 2'b10);

        // Clear raised mid-cycle with enable and data active.
        #10 clear = 1'b1;
        #1 check("seq_mid_clear", 2'b00);
        @(posedge clock); #1 check("seq_clear_over_edge", 2'b00);
        @(negedge clock);
        clear = 1'b0;
        #1 check("seq_release_wait", 2'b00);
        @(posedge clock); #1 check("seq_release_load", 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
